// File: rtl/line_fill_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | line_fill_buffer : requests a missed cache line and assembles 16 beats
// | into a 512-bit line. Optional: LINE_FILL_CRIT_WORD_EN (critical word first).
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module line_fill_buffer #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 32,
  parameter int LINE_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic [LINE_W-1:0] fill_line,
  output logic              fill_valid,
`ifdef LINE_FILL_CRIT_WORD_EN
  output logic              crit_valid,
`endif
  output logic              busy
);

  localparam int NUM_BEATS = LINE_W / BEAT_W;
  localparam int CNT_W     = $clog2(NUM_BEATS);
  localparam int OFF_W     = $clog2(LINE_W / 8);
  localparam int WB        = $clog2(BEAT_W / 8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        start_q, start_d;
  logic [ADDR_W-1:OFF_W]   tag_q, tag_d;
  logic [LINE_W-1:0]       line_q, line_d;

  logic [CNT_W-1:0]        w_start_word;
  logic [CNT_W-1:0]        w_slot;
  logic                    w_beat_wr;
  logic                    w_unused;

`ifdef LINE_FILL_CRIT_WORD_EN
  assign w_start_word = miss_addr[OFF_W-1:WB];
  assign w_unused     = ^miss_addr[WB-1:0];
`else
  assign w_start_word = '0;
  assign w_unused     = ^miss_addr[OFF_W-1:0];
`endif

  // Slot index wraps naturally through the counter width.
  assign w_slot = start_q + cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = start_q;
    tag_d     = tag_q;
    line_d    = line_q;
    w_beat_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          state_d = ST_REQ;
          tag_d   = miss_addr[ADDR_W-1:OFF_W];
          start_d = w_start_word;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        if (mem_ack) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (mem_rvalid) begin
          w_beat_wr = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_BEATS - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (w_beat_wr && (w_slot == CNT_W'(k))) line_d[k*BEAT_W +: BEAT_W] = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      start_q <= '0;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
    end
  end

`ifdef LINE_FILL_CRIT_WORD_EN
  logic crit_q;
  // Pulses the cycle after the first beat, when the missed word is already in line_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crit_q <= 1'b0;
    else     crit_q <= (state_q == ST_FILL) && mem_rvalid && (cnt_q == '0);
  end
  assign crit_valid = crit_q;
`endif

  assign miss_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign mem_req    = (state_q == ST_REQ);
  assign mem_addr   = mem_req ? {tag_q, start_q, {WB{1'b0}}} : '0;
  assign fill_line  = line_q;
  assign fill_valid = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_line_fill_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_line_fill_buffer : scoreboard bench for line_fill_buffer.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_line_fill_buffer;

  localparam int ADDR_W = 32;
  localparam int BEAT_W = 32;
  localparam int LINE_W = 512;
`ifdef LINE_FILL_CRIT_WORD_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [BEAT_W-1:0] mem_rdata;
  logic [LINE_W-1:0] fill_line;
  logic              fill_valid;
  logic              busy;
`ifdef LINE_FILL_CRIT_WORD_EN
  logic              crit_valid;
`endif

  line_fill_buffer #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .LINE_W(LINE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .miss_ready (miss_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .fill_line  (fill_line),
    .fill_valid (fill_valid),
`ifdef LINE_FILL_CRIT_WORD_EN
    .crit_valid (crit_valid),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int fv_count = 0;
  int t_done = 0;
  logic [LINE_W-1:0] held_line = '0;

  logic [LINE_W-1:0] exp_line_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int                exp_crit_idx_q[$];
  logic [BEAT_W-1:0] exp_crit_dat_q[$];

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expected responses whenever the DUT presents them.
  initial begin
    logic [ADDR_W-1:0] cur_addr;
    bit req_seen;
    bit prev_fv;
    cur_addr = '0;
    req_seen = 1'b0;
    prev_fv  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_seen = 1'b0;
        prev_fv  = 1'b0;
      end else begin
        if (mem_req) begin
          if (!req_seen) begin
            if (exp_addr_q.size() == 0) fail_now("spurious_mem_req");
            else cur_addr = exp_addr_q.pop_front();
            req_seen = 1'b1;
          end
          check("mem_addr", mem_addr, cur_addr);
        end else begin
          req_seen = 1'b0;
        end
        if (fill_valid) begin
          if (exp_line_q.size() == 0) fail_now("spurious_fill_valid");
          else check("fill_line", fill_line, exp_line_q.pop_front());
          check("busy_in_done", busy, 1'b1);
          t_done = cyc;
          fv_count++;
          prev_fv = 1'b1;
        end else if (prev_fv) begin
          check("fill_valid_pulse_end", {fill_valid, busy, miss_ready}, 3'b001);
          prev_fv = 1'b0;
        end
`ifdef LINE_FILL_CRIT_WORD_EN
        if (crit_valid) begin
          if (exp_crit_idx_q.size() == 0) fail_now("spurious_crit_valid");
          else begin
            int idx;
            idx = exp_crit_idx_q.pop_front();
            check("crit_word", fill_line[idx*BEAT_W +: BEAT_W], exp_crit_dat_q.pop_front());
          end
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pat=1: beats 0xA000_0000+k; gap_mode 0 none, 1 random, 2 three idles after beats 4 and 10.
  task automatic run_fill(input logic [ADDR_W-1:0] addr, input bit pat, input int gap_mode,
                          input bit strays, input int abort_after, input int ack_dly, output int lat);
    logic [BEAT_W-1:0] bt[16];
    logic [LINE_W-1:0] line;
    int st, t_acc, fv0, lim, g;
    lat = -1;
    for (int k = 0; k < 16; k++) bt[k] = pat ? (32'hA000_0000 + k) : $urandom();
    st = CRIT ? int'(addr[5:2]) : 0;
    line = '0;
    for (int j = 0; j < 16; j++) line[((st + j) % 16)*BEAT_W +: BEAT_W] = bt[j];

    lim = 0;
    while (!miss_ready && lim < 50) begin tick(); lim++; end
    check("miss_ready_idle", miss_ready, 1'b1);
    fv0 = fv_count;
    miss_req  = 1'b1;
    miss_addr = addr;
    exp_addr_q.push_back((addr & ~32'h3F) | ADDR_W'(st << 2));
    if (abort_after < 0) exp_line_q.push_back(line);
    if (CRIT) begin
      exp_crit_idx_q.push_back(st);
      exp_crit_dat_q.push_back(bt[0]);
    end
    tick();
    t_acc = cyc;
    miss_req = strays;
    miss_addr = $urandom();
    check("busy_after_accept", {busy, miss_ready}, 2'b10);
    check("line_hold_req", fill_line, held_line);

    for (int d = 0; d < ack_dly; d++) begin
      mem_rvalid = strays;
      mem_rdata  = $urandom();
      tick();
    end
    mem_ack    = 1'b1;
    mem_rvalid = strays;
    mem_rdata  = $urandom();
    tick();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    check("line_hold_pre_fill", fill_line, held_line);

    for (int j = 0; j < 16; j++) begin
      if (j == abort_after) begin
        rst = 1'b1;
        #1;
        check("abort_line", fill_line, '0);
        check("abort_ctrl", {miss_ready, busy, mem_req, fill_valid}, 4'b1000);
        tick();
        rst = 1'b0;
        miss_req = 1'b0;
        held_line = '0;
        exp_crit_idx_q.delete();
        exp_crit_dat_q.delete();
        for (int w = 0; w < 20; w++) tick();
        check("abort_no_fill_valid", fv_count - fv0, 0);
        check("abort_line_after", fill_line, '0);
        return;
      end
      g = 0;
      if (gap_mode == 1 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
      if (gap_mode == 2 && (j == 5 || j == 11)) g = 3;
      for (int gi = 0; gi < g; gi++) begin
        mem_ack = strays;
        tick();
        mem_ack = 1'b0;
        check("miss_ready_in_fill", miss_ready, 1'b0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = bt[j];
      mem_ack    = strays && (j % 3 == 0);
      tick();
      mem_rvalid = 1'b0;
      mem_ack    = 1'b0;
    end
    miss_req = 1'b0;
    lim = 0;
    while (busy && lim < 5) begin tick(); lim++; end
    check("fill_valid_once", fv_count - fv0, 1);
    held_line = line;
    lat = t_done - t_acc;
  endtask

  initial begin
    int lat_base, lat_gap, lat;
    rst        = 1'b1;
    miss_req   = 1'b0;
    miss_addr  = '0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #12;
    check("reset_line", fill_line, '0);
    check("reset_ctrl", {miss_ready, busy, mem_req, fill_valid}, 4'b1000);
    check("reset_mem_addr", mem_addr, '0);
    tick();
    rst = 1'b0;
    tick();

    // Basic fill; 17 edges from accept to fill_valid = 19-cycle minimum latency.
    run_fill(32'h0000_1234, 1'b1, 0, 1'b0, -1, 0, lat_base);
    check("base_latency", lat_base, 17);

    // Hold after done
    for (int i = 0; i < 10; i++) tick();
    check("hold_after_done", fill_line, held_line);

    run_fill(32'h0000_1238, 1'b1, 0, 1'b0, -1, 1, lat);
    run_fill(32'h0000_1238, 1'b1, 2, 1'b0, -1, 0, lat_gap);
    check("gap_latency_delta", lat_gap - lat_base, 6);

    run_fill(32'h8000_00C4, 1'b0, 0, 1'b1, -1, 2, lat);
    run_fill(32'h0000_0F3C, 1'b0, 1, 1'b0, 8, 0, lat);
    check("ready_after_abort", miss_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run_fill($urandom(), 1'b0, $urandom_range(0, 1), 1'(($urandom_range(0, 1))),
               -1, $urandom_range(0, 3), lat);
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) tick();
    end

    for (int i = 0; i < 4; i++) tick();
    check("line_q_drained", exp_line_q.size(), 0);
    check("addr_q_drained", exp_addr_q.size(), 0);
    check("crit_q_drained", exp_crit_idx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Refill stage directly upstream of the cache load-data aligner.
- On a read miss, requests the missing 64-byte line from main memory and collects it as 16 sequential 32-bit beats into a 512-bit line register.
- Presents the assembled line as the main-memory line data to the load aligner and the bank write path, and pulses a fill-complete strobe.
- Owns the refill handshake so the cache controller only sees "miss accepted" and "line ready".

Parameters:
- ADDR_W, 32, byte address width.
- BEAT_W, 32, main-memory data beat width; fixed at 32 in this revision.
- LINE_W, 512, cache line width in bits; NUM_BEATS = LINE_W/BEAT_W = 16, offset width = 6.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- miss_req  input  1  controller requests a line fill.
- miss_addr  input  ADDR_W  byte address of the missing access.
- miss_ready  output  1  high only in IDLE; miss accepted when miss_req && miss_ready.
- mem_req  output  1  read request to main memory; held until mem_ack.
- mem_addr  output  ADDR_W  first-beat byte address, held while mem_req is high.
- mem_ack  input  1  memory accepted the request.
- mem_rvalid  input  1  a read beat is present on mem_rdata.
- mem_rdata  input  BEAT_W  read beat.
- fill_line  output  LINE_W  assembled line; word k occupies bits [32k+31:32k].
- fill_valid  output  1  one-cycle pulse when all 16 beats are stored.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous: state IDLE; beat counter 0; captured address 0; fill_line all zeros; mem_req, mem_addr, fill_valid and busy all 0; miss_ready 1.
- State machine, registered, one transition per clk:
  - IDLE -> REQ when miss_req is high. In the same edge, capture miss_addr and set start word = miss_addr[5:2] (or 0, see Optional Feature).
  - REQ -> FILL on mem_ack. mem_req is high for the whole of REQ. mem_addr = {captured_addr[ADDR_W-1:6], start_word, 2'b00}.
  - FILL -> DONE when the beat with count 15 is accepted. Each mem_rvalid writes mem_rdata to word slot (start_word + count) mod 16, then count increments. The slot index wraps from 15 to 0.
  - DONE -> IDLE after one cycle. fill_valid = 1 only in DONE.
- Latency: fill_valid asserts the cycle after the 16th beat is accepted. Minimum miss-accept to fill_valid is 19 cycles (1 REQ + 16 beats + 1 DONE + 1 capture edge).
- fill_line holds its value from DONE until the next beat is written. It does not clear on a new miss, so the downstream aligner sees stable data after fill_valid.
- The counter advances only on mem_rvalid. Gaps between beats are allowed and the count holds during them.
- Beats arriving in IDLE, REQ or DONE are ignored. This includes a beat in the same cycle as mem_ack; memory returns its first beat no earlier than the cycle after mem_ack.
- miss_req outside IDLE is ignored (miss_ready = 0). The controller must hold the request.
- mem_ack outside REQ is ignored.
- Reset mid-REQ or mid-FILL aborts the fill: all outputs return to reset values, fill_valid never pulses, and partially written words are cleared.
- No back-to-back fills: the earliest next acceptance is the cycle after DONE (in IDLE).

Optional Feature:
- Macro: LINE_FILL_CRIT_WORD_EN.
- Defined: critical-word-first. start_word = miss_addr[5:2]; the first beat is the missed word, then sequential with wrap. Adds an output crit_valid (1 bit). crit_valid is a one-cycle pulse in the cycle after the first beat is stored; at that point fill_line already holds the missed word, so the aligner can restart early. crit_valid resets to 0.
- Undefined: start_word is forced to 0, mem_addr is line-aligned, beats fill words 0..15 in order, and the crit_valid port does not exist.

Test Plan:
- Basic fill, macro off: miss_addr=0x0000_1234, mem_ack one cycle after mem_req, 16 consecutive beats 0xA000_0000+k. Required: mem_addr = 0x0000_1200; word k = 0xA000_0000+k; fill_valid is a single pulse the cycle after beat 15; busy falls with it.
- Critical word first, macro on: miss_addr=0x0000_1238 (word 14). Required: mem_addr = 0x0000_1238; beats land in words 14,15,0..13; crit_valid pulses after the first beat, with fill_line[479:448] = first beat.
- Gapped beats: 3 idle cycles inserted after beats 4 and 10. Required: no slot skipped or duplicated; fill_valid delayed by exactly 6 cycles versus the gap-free run.
- Ignored events: a stray mem_rvalid while in REQ, a second miss_req during FILL, and mem_ack during FILL. Required: no write to fill_line, miss_ready stays 0, and the fill completes normally.
- Reset mid-fill: assert rst after beat 7. Required: fill_line = 0, fill_valid never pulses, and state returns to IDLE with miss_ready = 1 immediately, without waiting for a clock edge.
- Hold after done: after a complete fill, idle for 10 cycles. Required: fill_line unchanged; the next miss does not alter fill_line until its first beat is accepted.
